// File: rtl/mux16_sched_pkg.sv
// +-------------------------------------------------------------------------+
// | mux16_sched_pkg : shared constants and state type for 16-way scheduler  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package mux16_sched_pkg;

   localparam int N_REQ  = 16;
   localparam int SEL_W  = 4;
   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } sched_state_e;

   function automatic logic [N_REQ-1:0] sel_to_oh(input logic [SEL_W-1:0] sel);
      return N_REQ'(1) << sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick16.sv
// +-------------------------------------------------------------------------+
// | rr_pick16 : circular first-set-bit picker starting after last_ptr       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module rr_pick16
   import mux16_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last_ptr,
   output logic             any_req,
   output logic [SEL_W-1:0] winner
);

   logic [SEL_W-1:0]   base;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [SEL_W-1:0]   offset;
   logic               found;

   // Rotate so the highest-priority requester lands at bit 0, then take the
   // lowest set bit; the 4-bit add wraps the offset back to a real index.
   always_comb begin
      base   = last_ptr + SEL_W'(1);
      dbl    = {req, req} >> base;
      rot    = dbl[N_REQ-1:0];
      offset = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && rot[i]) begin
            offset = SEL_W'(i);
            found  = 1'b1;
         end
      end
      winner  = base + offset;
      any_req = |req;
   end

endmodule

`default_nettype wire

// File: rtl/mux16_rr_sched.sv
// +-------------------------------------------------------------------------+
// | mux16_rr_sched : round-robin owner of a shared 16:1 mux select          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module mux16_rr_sched
   import mux16_sched_pkg::*;
#(
   parameter int MAX_HOLD = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   // "release" is a reserved word, so the owner's end-of-grant pulse is renamed
   input  logic             release_pulse,
   output logic             grant_valid,
   output logic [SEL_W-1:0] grant_idx,
   output logic [N_REQ-1:0] grant_oh,
   output logic             timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   sched_state_e     state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
   logic             grant_valid_q, grant_valid_d;
   logic [SEL_W-1:0] grant_idx_q, grant_idx_d;
   logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
   logic             timeout_q, timeout_d;

   logic             any_req;
   logic [SEL_W-1:0] winner;
   logic             hold_hit;
   logic             owner_drop;

   rr_pick16 u_pick (
      .req      (req),
      .last_ptr (last_ptr_q),
      .any_req  (any_req),
      .winner   (winner)
   );

   assign hold_hit   = (hold_cnt_q == HOLD_LAST);
   assign owner_drop = ~req[grant_idx_q];

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      last_ptr_d    = last_ptr_q;
      grant_valid_d = grant_valid_q;
      grant_idx_d   = grant_idx_q;
      grant_oh_d    = grant_oh_q;
      timeout_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && any_req) begin
               state_d       = GRANT;
               grant_valid_d = 1'b1;
               grant_idx_d   = winner;
               grant_oh_d    = sel_to_oh(winner);
               hold_cnt_d    = '0;
            end
         end
         GRANT: begin
            if (release_pulse || owner_drop || hold_hit) begin
               state_d       = GAP;
               grant_valid_d = 1'b0;
               grant_oh_d    = '0;
               last_ptr_d    = grant_idx_q;
               // Only a forced end is reported; a voluntary end wins a tie.
               timeout_d     = hold_hit && !release_pulse && !owner_drop;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // grant_idx is left untouched on grant end so the mux select stays quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         last_ptr_q    <= SEL_W'(N_REQ - 1);
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         grant_oh_q    <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         last_ptr_q    <= last_ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
         grant_oh_q    <= grant_oh_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign grant_oh    = grant_oh_q;
   assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 16:1 single-bit mux tree between 16 requesters.
- Each requester owns one mux input. The scheduler grants one requester at a time and drives the registered 4-bit select into the mux tree's select input.
- Grants are held until release, request drop or timeout.
- Sits directly in front of the 16:1 mux. The granted requester reads the mux output.

Parameters:
- MAX_HOLD, 8, maximum grant duration in cycles before forced release (legal range 1..255).

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  when 0, no new grant is issued; a grant already in progress continues.
- req  input  16  per-requester request, level-sensitive; bit i = mux input i.
- release  input  1  single-cycle pulse from the current owner ending its grant.
- grant_valid  output  1  a grant is active.
- grant_idx  output  4  registered mux select; index of the owner.
- grant_oh  output  16  one-hot copy of grant_idx, qualified by grant_valid (all-zero when idle).
- timeout  output  1  one-cycle pulse when a grant is forcibly ended at MAX_HOLD.

Behaviour:
- Reset values (synchronous, takes effect on the clk edge with rst=1):
  - grant_valid=0, grant_idx=0, grant_oh=0, timeout=0.
  - State IDLE, hold_cnt=0, last_ptr=15, so index 0 has first priority after reset.
- Reset has priority over every other input.
- Reset mid-grant drops the grant on that edge. No timeout pulse is produced.
- States:
  - IDLE:
    - When en=1 and req!=0, pick the first set bit scanning circularly from last_ptr+1 upward, wrapping 15->0.
    - Next edge: grant_valid=1, grant_idx=winner, grant_oh=1<<winner, hold_cnt=0, state GRANT.
    - Latency from request sampled to grant visible is 1 cycle.
  - GRANT:
    - hold_cnt increments each cycle.
    - The grant ends on the next edge when any of these holds:
      - release=1
      - req[grant_idx]=0
      - hold_cnt==MAX_HOLD-1
    - On end: grant_valid=0, grant_oh=0, last_ptr=grant_idx, state GAP.
    - timeout=1 for that one cycle only when the end is caused solely by hold_cnt reaching MAX_HOLD-1. If release or the request drop happens in the same cycle, timeout=0.
    - With MAX_HOLD=1 the grant is exactly one cycle long.
  - GAP:
    - One mandatory dead cycle so mux select settles. No grant is issued.
    - Next state is IDLE. Arbitration occurs in IDLE, so the minimum spacing between grants is 2 idle cycles.
- grant_idx keeps its last value while grant_valid=0, so the mux select never toggles spuriously.
- release, and changes on other req bits, are ignored outside GRANT.
- Requests arriving while en=0 wait. Arbitration resumes on the first IDLE cycle with en=1.
- A single requester with req held high is re-granted after each GAP. This still honours MAX_HOLD.
- hold_cnt is 8 bits wide and never wraps, because it is cleared on every grant.

Decomposition:
- Package mux16_sched_pkg contains:
  - N_REQ=16, SEL_W=4.
  - State enum {IDLE, GRANT, GAP}.
- One combinational sub-module, rr_pick16:
  - Inputs: req[15:0], last_ptr[3:0].
  - Outputs: any_req, winner[3:0].
  - Implementation: rotate-then-priority-encode. It is reusable by other 16-way schedulers.

Test Plan:
- Reset, then req=16'h0001 with en=1: grant_valid=1 and grant_idx=0 one cycle after req is sampled; grant_oh=16'h0001.
- req=16'h8101 held, owners release after 2 cycles: grants issued in order 0, 8, 15, 0, each separated by the GAP cycle.
- MAX_HOLD=4, req=16'h0010 held, no release: grant_valid high exactly 4 cycles, timeout pulses once, re-grant to index 4 after GAP.
- In GRANT with owner 3, req[3] drops while req[5]=1: grant ends next edge, timeout=0, next grant is to 5, grant_idx stays 3 during the dead cycles.
- en=0 with req=16'hFFFF: no grant. en raised: grant goes to index 0 after reset (last_ptr=15). A grant already running while en falls continues until release.
- rst asserted for one cycle mid-grant (owner 7): next cycle all outputs are 0, and with req=16'h0080 still set the first new grant is index 7 after IDLE arbitration.
